// File: rtl/rabbit_bus_pkg.sv
// Frame layout constants shared by the Rabbit bus writer and reader, plus the
// writer's FSM state encoding.
package rabbit_bus_pkg;

  // SCLK rising edges per frame; the reader wraps its edge counter at this value.
  localparam int RB_FRAME_BITS   = 184;
  // FTW-high field: frame positions 120..151, FTW[31] sent first at position 120.
  localparam int RB_FTW_HIGH_POS = 120;
  localparam int RB_FTW_HIGH_W   = 32;

  typedef enum logic [1:0] {
    RB_IDLE = 2'd0,
    RB_LOW  = 2'd1,
    RB_HIGH = 2'd2,
    RB_GAP  = 2'd3
  } rb_state_e;

endpackage

// File: rtl/rabbit_frame_writer_sclk_tick_gen.sv
// Half-period tick generator for SCLK. Counts CLK_DIV cycles while enabled and
// pulses tick on the last one. The count is held at zero while disabled, so every
// enable starts a full half-period.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: advance while enabled, restart after the terminal value or when disabled.
  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rabbit_frame_writer.sv
// Serialises one DDS programming frame onto the two-wire Rabbit bus.
// frame_data[0] is sent on SCLK rising edge 0. SDIO changes only while SCLK
// falls, so it is stable for CLK_DIV cycles on both sides of every rising edge.
//
// Handshake: a frame is accepted on a rising CLK_SYS edge where frame_valid and
// frame_ready are both high. frame_ready is high only in IDLE. frame_valid is
// ignored at all other times and is never queued. frame_data is sampled only on
// the accepting edge.
module rabbit_frame_writer
  import rabbit_bus_pkg::*;
#(
  parameter int FRAME_BITS = RB_FRAME_BITS,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  CLK_SYS,
  input  logic                  RESET_N,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  SCLK_PE3,
  output logic                  SDIO_PE5,
  output rb_state_e             state_dbg
);

  localparam int BW = $clog2(FRAME_BITS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  rb_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  sdio_q, sdio_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  tick_en;

  // The divider runs only while SCLK is being generated, so it restarts at zero for every frame.
  assign tick_en = (state_q == RB_LOW) || (state_q == RB_HIGH);

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (CLK_SYS),
    .rst_n (RESET_N),
    .en    (tick_en),
    .tick  (tick)
  );

  // FSM next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    sdio_d    = sdio_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    case (state_q)
      RB_IDLE: begin
        if (frame_valid && ready_q) begin
          state_d   = RB_LOW;
          shreg_d   = frame_data;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          sdio_d    = frame_data[0];
          busy_d    = 1'b1;
          ready_d   = 1'b0;
        end
      end
      RB_LOW: begin
        if (tick) begin
          state_d = RB_HIGH;
          sclk_d  = 1'b1;
        end
      end
      RB_HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            // The last falling edge ends the frame. Both data and shifter are cleared.
            sdio_d    = 1'b0;
            shreg_d   = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            done_d    = 1'b1;
            if (GAP_CYCLES == 0) begin
              state_d = RB_IDLE;
              busy_d  = 1'b0;
              ready_d = 1'b1;
            end else begin
              state_d = RB_GAP;
            end
          end else begin
            // The falling edge presents the next bit.
            state_d   = RB_LOW;
            shreg_d   = shreg_q >> 1;
            sdio_d    = shreg_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      RB_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = RB_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RB_IDLE;
      end
    endcase
  end

  // State and output registers. Reset forces SCLK low at once and drops any frame in flight.
  always_ff @(posedge CLK_SYS or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= RB_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdio_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      sdio_q    <= sdio_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign SCLK_PE3    = sclk_q;
  assign SDIO_PE5    = sdio_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_rabbit_frame_writer.sv
// Bench for rabbit_frame_writer. Instance 0 uses CLK_DIV=4 and GAP_CYCLES=8.
// Instance 1 uses CLK_DIV=1 and GAP_CYCLES=0. A reader model on each bus
// rebuilds the FTW-high word and compares it against the expected-word queue.
module tb_rabbit_frame_writer;
  import rabbit_bus_pkg::*;

  localparam int FB  = RB_FRAME_BITS;
  localparam int POS = RB_FTW_HIGH_POS;
  localparam int FW  = RB_FTW_HIGH_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FB-1:0] fd0, fd1;
  logic [1:0]    fv;
  logic [1:0]    ready_v, busy_v, done_v, sclk_v, sdio_v;
  rb_state_e     st0, st1;

  rabbit_frame_writer #(.FRAME_BITS(FB), .CLK_DIV(4), .GAP_CYCLES(8)) dut0 (
    .CLK_SYS(clk), .RESET_N(rst_n), .frame_data(fd0), .frame_valid(fv[0]),
    .frame_ready(ready_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]),
    .SCLK_PE3(sclk_v[0]), .SDIO_PE5(sdio_v[0]), .state_dbg(st0));

  rabbit_frame_writer #(.FRAME_BITS(FB), .CLK_DIV(1), .GAP_CYCLES(0)) dut1 (
    .CLK_SYS(clk), .RESET_N(rst_n), .frame_data(fd1), .frame_valid(fv[1]),
    .frame_ready(ready_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]),
    .SCLK_PE3(sclk_v[1]), .SDIO_PE5(sdio_v[1]), .state_dbg(st1));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp6_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus monitor / reader model ----------------
  int          edge_pos[2], edges[2], rises_since_acc[2], acc_cnt[2];
  int          first_rise[2], last_rise[2], done_cyc[2], done_cnt[2], ready_cyc[2], unstable[2];
  logic [31:0] ftw_sh[2];
  logic [1:0]  sclk_p, sdio_p, ready_p;

  initial begin
    for (int i = 0; i < 2; i++) begin
      edge_pos[i] = 0; edges[i] = 0; rises_since_acc[i] = 0; acc_cnt[i] = 0;
      first_rise[i] = 0; last_rise[i] = 0; done_cyc[i] = 0; done_cnt[i] = 0;
      ready_cyc[i] = 0; unstable[i] = 0; ftw_sh[i] = '0;
    end
    sclk_p = '0; sdio_p = '0; ready_p = '0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        edge_pos[i] = 0;
        ftw_sh[i]   = '0;
      end else begin
        if (fv[i] && ready_v[i]) begin
          acc_cnt[i]++;
          rises_since_acc[i] = 0;
        end
        if (sclk_v[i] && !sclk_p[i]) begin
          if (sdio_v[i] !== sdio_p[i]) unstable[i]++;
          if (rises_since_acc[i] == 0) first_rise[i] = cyc;
          rises_since_acc[i]++;
          last_rise[i] = cyc;
          edges[i]++;
          if (edge_pos[i] >= POS && edge_pos[i] < POS + FW)
            ftw_sh[i] = {ftw_sh[i][30:0], sdio_v[i]};
          if (edge_pos[i] == POS + FW - 1) begin
            if (i == 0) begin
              check("word_expected0", {31'd0, exp_q.size() > 0}, 32'd1);
              if (exp_q.size() > 0) check("ftw_word0", ftw_sh[i], exp_q.pop_front());
            end else begin
              check("word_expected1", {31'd0, exp6_q.size() > 0}, 32'd1);
              if (exp6_q.size() > 0) check("ftw_word1", ftw_sh[i], exp6_q.pop_front());
            end
          end
          edge_pos[i] = (edge_pos[i] == FB - 1) ? 0 : edge_pos[i] + 1;
        end
        if (done_v[i]) begin
          done_cyc[i] = cyc;
          done_cnt[i]++;
        end
        if (ready_v[i] && !ready_p[i]) ready_cyc[i] = cyc;
      end
      sclk_p[i]  = sclk_v[i];
      sdio_p[i]  = sdio_v[i];
      ready_p[i] = ready_v[i];
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [FB-1:0] build_frame(input logic [31:0] w);
    logic [FB-1:0] f;
    for (int k = 0; k < FB; k++) f[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < FW; k++) f[POS + k] = w[31 - k];
    return f;
  endfunction

  task automatic send_frame(input int i, input logic [FB-1:0] d, output int t);
    int n;
    @(posedge clk); #1;
    if (i == 0) fd0 = d; else fd1 = d;
    fv[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_v[i] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("accept", {31'd0, ready_v[i]}, 32'd1);
    t = cyc;
    @(posedge clk); #1;
    fv[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_v[i] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("ready_return", {31'd0, ready_v[i]}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, t2, e, dc, ac, n;
    logic [FB-1:0] f1, f2;
    rst_n = 1'b0;
    fv    = '0;
    fd0   = '0;
    fd1   = '0;

    // 1: reset values and a quiet bus while idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", {30'd0, sclk_v}, 32'd0);
    check("rst_sdio", {30'd0, sdio_v}, 32'd0);
    check("rst_busy", {30'd0, busy_v}, 32'd0);
    check("rst_done", {30'd0, done_v}, 32'd0);
    check("rst_state", {30'd0, st0}, {30'd0, RB_IDLE});
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {30'd0, ready_v}, 32'd3);
    e = edges[0] + edges[1];
    repeat (100) @(negedge clk);
    check("idle_edges", edges[0] + edges[1] - e, 32'd0);

    // 2: single frame with timing.
    exp_q.push_back(32'hDEADBEEF);
    e  = edges[0];
    dc = done_cnt[0];
    send_frame(0, build_frame(32'hDEADBEEF), t);
    wait_ready(0);
    check("t2_edges", edges[0] - e, FB);
    check("t2_first_rise", first_rise[0], t + 5);
    check("t2_done_cyc", done_cyc[0], t + 1473);
    check("t2_done_cnt", done_cnt[0] - dc, 32'd1);
    check("t2_ready_cyc", ready_cyc[0], t + 1481);
    check("t2_queue", exp_q.size(), 32'd0);

    // 3: frame_valid held high for two frames.
    f1 = build_frame(32'hDEADBEEF);
    f2 = build_frame(32'h12345678);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    e = edges[0];
    @(posedge clk); #1;
    fd0 = f1; fv[0] = 1'b1;
    @(negedge clk);
    t = cyc;
    check("t3_accept1", {31'd0, ready_v[0]}, 32'd1);
    @(posedge clk); #1;
    fd0 = f2;
    n = 0;
    @(negedge clk);
    while (!ready_v[0] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    check("t3_accept2", {31'd0, ready_v[0]}, 32'd1);
    @(posedge clk); #1;
    fv[0] = 1'b0;
    wait_ready(0);
    check("t3_spacing", t2 - t, 32'd1481);
    check("t3_first_rise2", first_rise[0], t2 + 5);
    check("t3_edges", edges[0] - e, 2 * FB);
    check("t3_queue", exp_q.size(), 32'd0);

    // 4: new request and new data while busy are ignored.
    exp_q.push_back(32'h0BADF00D);
    e  = edges[0];
    ac = acc_cnt[0];
    send_frame(0, build_frame(32'h0BADF00D), t);
    repeat (300) @(posedge clk);
    #1;
    fd0 = build_frame(32'hCAFEF00D);
    fv[0] = 1'b1;
    @(posedge clk); #1;
    fv[0] = 1'b0;
    wait_ready(0);
    repeat (50) @(negedge clk);
    check("t4_edges", edges[0] - e, FB);
    check("t4_accepts", acc_cnt[0] - ac, 32'd1);
    check("t4_busy", {31'd0, busy_v[0]}, 32'd0);
    check("t4_queue", exp_q.size(), 32'd0);

    // 5: reset at edge 60 loses the frame, then the next frame is clean.
    exp_q.push_back(32'hFFFFFFFF);
    send_frame(0, build_frame(32'hFFFFFFFF), t);
    n = 0;
    while (rises_since_acc[0] < 60 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_edge60", rises_since_acc[0], 32'd60);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_sclk_low", {31'd0, sclk_v[0]}, 32'd0);
    check("t5_busy_low", {31'd0, busy_v[0]}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    e = edges[0];
    send_frame(0, build_frame(32'hA5A5A5A5), t);
    wait_ready(0);
    check("t5_edges", edges[0] - e, FB);
    check("t5_queue", exp_q.size(), 32'd0);

    // 6: CLK_DIV=1 with no gap.
    exp6_q.push_back(32'h3C3CC3C3);
    e = edges[1];
    send_frame(1, build_frame(32'h3C3CC3C3), t);
    wait_ready(1);
    check("t6_edges", edges[1] - e, FB);
    check("t6_first_rise", first_rise[1], t + 2);
    check("t6_last_rise", last_rise[1], t + 2 + 2 * (FB - 1));
    check("t6_done_cyc", done_cyc[1], t + 369);
    check("t6_ready_cyc", ready_cyc[1], t + 369);
    check("t6_queue", exp6_q.size(), 32'd0);

    check("sdio_stable0", unstable[0], 32'd0);
    check("sdio_stable1", unstable[1], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
